// File: rtl/tinisoc_pkg.sv
// TiniSOC shared definitions: opcodes, FSM states, ALU ops.
// Imported by the core and the register file.
package tinisoc_pkg;

   localparam logic [5:0] OP_ALU1 = 6'b100000;
   localparam logic [5:0] OP_ADDI = 6'b101000;
   localparam logic [5:0] OP_ORI  = 6'b101100;
   localparam logic [5:0] OP_XORI = 6'b101011;
   localparam logic [5:0] OP_MOVI = 6'b100010;
   localparam logic [5:0] OP_LWI  = 6'b000010;
   localparam logic [5:0] OP_SWI  = 6'b001010;
   localparam logic [5:0] OP_MEMX = 6'b011100;

   localparam logic [4:0] SUB_ADD   = 5'b00000;
   localparam logic [4:0] SUB_SUB   = 5'b00001;
   localparam logic [4:0] SUB_AND   = 5'b00010;
   localparam logic [4:0] SUB_XOR   = 5'b00011;
   localparam logic [4:0] SUB_OR    = 5'b00100;
   localparam logic [4:0] SUB_SLLI  = 5'b01000;
   localparam logic [4:0] SUB_SRLI  = 5'b01001;
   localparam logic [4:0] SUB_ROTRI = 5'b01011;

   localparam logic [7:0] SUBX_LW = 8'b00000010;
   localparam logic [7:0] SUBX_SW = 8'b00001010;

   typedef enum logic [2:0] {
      FETCH, DECODE, EXEC, MEM, WB
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_OR,
      ALU_SLL, ALU_SRL, ALU_ROR, ALU_PASSB, ALU_NOP
   } alu_op_t;

   function automatic logic [31:0] sext15(input logic [14:0] v);
      return {{17{v[14]}}, v};
   endfunction

endpackage

// File: rtl/tinisoc_regfile.sv
// TiniSOC register file: two async read ports, one sync write port.
// All registers clear on reset; r0 is an ordinary register.
module tinisoc_regfile
   import tinisoc_pkg::*;
#(
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] ra_addr,
   input  logic [AW-1:0] rb_addr,
   output logic [31:0]   ra_data,
   output logic [31:0]   rb_data,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [31:0]   wd
);

   logic [31:0] rw_reg [0:NREG-1];

   assign ra_data = rw_reg[ra_addr];
   assign rb_data = rw_reg[rb_addr];

   // Register storage: clear on reset, otherwise single write port.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            rw_reg[i] <= '0;
         end
      end else if (we) begin
         rw_reg[wa] <= wd;
      end
   end

endmodule

// File: rtl/tinisoc_core.sv
// TiniSOC 32-bit multi-cycle core, 5 clocks per instruction.
// FETCH, DECODE, EXEC, MEM, WB; decoder and ALU inline.
module tinisoc_core
   import tinisoc_pkg::*;
#(
   parameter int PC_W = 10,
   parameter int DA_W = 12,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     instruction,
   output logic            alu_overflow,
   output logic [PC_W-1:0] pc,
   output logic            IM_read,
   output logic            IM_write,
   output logic            IM_enable,
   output logic            DM_read,
   output logic            DM_write,
   output logic            DM_enable,
   output logic [DA_W-1:0] DM_address,
   output logic [31:0]     DM_in,
   input  logic [31:0]     DM_out
);

   state_t      state, state_nx;
   alu_op_t     alu_op;
   logic [31:0] ir, a_q, b_q, res_q;
   logic [31:0] opb, alu_res, ea;
   logic [31:0] rd_a_data, rd_b_data;
   logic [4:0]  rd_a, rd_b;
   logic        is_load, is_store, wr_rt, ov_nx;
   logic        unused_bits;

   wire [5:0] op     = ir[30:25];
   wire [4:0] rt     = ir[24:20];
   wire [4:0] shamt  = ir[14:10];
   wire [4:0] sub5   = ir[4:0];
   wire [7:0] sub8   = ir[7:0];

   assign unused_bits = ^{ir[31], ea[31:DA_W]};
   assign IM_write    = 1'b0;

   // Operand ports see the incoming word in DECODE, rt in EXEC.
   assign rd_a = (state == DECODE) ? instruction[19:15] : ir[19:15];
   assign rd_b = (state == DECODE) ? instruction[14:10] : rt;

   tinisoc_regfile #(.NREG(NREG)) REGFILE (
      .clk     (clk),
      .rst     (rst),
      .ra_addr (rd_a),
      .rb_addr (rd_b),
      .ra_data (rd_a_data),
      .rb_data (rd_b_data),
      .we      ((state == WB) && wr_rt),
      .wa      (rt),
      .wd      (is_load ? DM_out : res_q)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state <= FETCH;
      else      state <= state_nx;
   end

   // Next state and memory strobes; strobes are held low while
   // reset is asserted so an aborted store never reaches the DM.
   always_comb begin
      state_nx  = state;
      IM_enable = 1'b0;
      IM_read   = 1'b0;
      DM_enable = 1'b0;
      DM_read   = 1'b0;
      DM_write  = 1'b0;
      case (state)
         FETCH: begin
            state_nx  = DECODE;
            IM_enable = rst;
            IM_read   = rst;
         end
         DECODE: state_nx = EXEC;
         EXEC:   state_nx = MEM;
         MEM: begin
            state_nx  = WB;
            DM_enable = rst & (is_load | is_store);
            DM_read   = rst & is_load;
            DM_write  = rst & is_store;
         end
         WB:      state_nx = FETCH;
         default: state_nx = FETCH;
      endcase
   end

   // Instruction decode from the latched IR.
   always_comb begin
      alu_op   = ALU_NOP;
      opb      = b_q;
      is_load  = 1'b0;
      is_store = 1'b0;
      unique case (1'b1)
         (op == OP_ALU1): begin
            case (sub5)
               SUB_ADD:   alu_op = ALU_ADD;
               SUB_SUB:   alu_op = ALU_SUB;
               SUB_AND:   alu_op = ALU_AND;
               SUB_XOR:   alu_op = ALU_XOR;
               SUB_OR:    alu_op = ALU_OR;
               SUB_SLLI:  alu_op = ALU_SLL;
               SUB_SRLI:  alu_op = ALU_SRL;
               SUB_ROTRI: alu_op = ALU_ROR;
               default:   alu_op = ALU_NOP;
            endcase
         end
         (op == OP_ADDI): begin
            alu_op = ALU_ADD;
            opb    = sext15(ir[14:0]);
         end
         (op == OP_ORI): begin
            alu_op = ALU_OR;
            opb    = {17'b0, ir[14:0]};
         end
         (op == OP_XORI): begin
            alu_op = ALU_XOR;
            opb    = {17'b0, ir[14:0]};
         end
         (op == OP_MOVI): begin
            alu_op = ALU_PASSB;
            opb    = {{12{ir[19]}}, ir[19:0]};
         end
         (op == OP_LWI): is_load  = 1'b1;
         (op == OP_SWI): is_store = 1'b1;
         (op == OP_MEMX): begin
            is_load  = (sub8 == SUBX_LW);
            is_store = (sub8 == SUBX_SW);
         end
         default: ;
      endcase
   end

   assign wr_rt = (alu_op != ALU_NOP) | is_load;

   assign ea = (op == OP_MEMX)
             ? a_q + (b_q << ir[9:8])
             : a_q + (sext15(ir[14:0]) << 2);

   // ALU; overflow holds unless the op is an add or subtract.
   always_comb begin
      alu_res = '0;
      ov_nx   = alu_overflow;
      case (alu_op)
         ALU_ADD: begin
            alu_res = a_q + opb;
            ov_nx   = (a_q[31] == opb[31])
                    && (alu_res[31] != a_q[31]);
         end
         ALU_SUB: begin
            alu_res = a_q - opb;
            ov_nx   = (a_q[31] != opb[31])
                    && (alu_res[31] != a_q[31]);
         end
         ALU_AND:   alu_res = a_q & opb;
         ALU_XOR:   alu_res = a_q ^ opb;
         ALU_OR:    alu_res = a_q | opb;
         ALU_SLL:   alu_res = a_q << shamt;
         ALU_SRL:   alu_res = a_q >> shamt;
         ALU_ROR:   alu_res = 32'({a_q, a_q} >> shamt);
         ALU_PASSB: alu_res = opb;
         default:   alu_res = '0;
      endcase
   end

   // Datapath registers advanced by the current state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc           <= '0;
         ir           <= '0;
         a_q          <= '0;
         b_q          <= '0;
         res_q        <= '0;
         alu_overflow <= 1'b0;
         DM_address   <= '0;
         DM_in        <= '0;
      end else begin
         case (state)
            DECODE: begin
               ir  <= instruction;
               a_q <= rd_a_data;
               b_q <= rd_b_data;
            end
            EXEC: begin
               res_q        <= alu_res;
               alu_overflow <= ov_nx;
               if (is_load | is_store) DM_address <= ea[DA_W-1:0];
               if (is_store)           DM_in      <= rd_b_data;
            end
            WB:      pc <= pc + PC_W'(4);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tinisoc_core.sv
// Bench for tinisoc_core: ISS reference model, scoreboard queues
// for fetch pc, overflow and stores, and a reset-abort check.
module tb_tinisoc_core;

   localparam logic [5:0] T_ALU1 = 6'b100000;
   localparam logic [5:0] T_ADDI = 6'b101000;
   localparam logic [5:0] T_ORI  = 6'b101100;
   localparam logic [5:0] T_XORI = 6'b101011;
   localparam logic [5:0] T_MOVI = 6'b100010;
   localparam logic [5:0] T_LWI  = 6'b000010;
   localparam logic [5:0] T_SWI  = 6'b001010;
   localparam logic [5:0] T_MEMX = 6'b011100;
   localparam int N_DIR = 22;
   localparam int STEPS = 280;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] instruction = '0;
   logic [31:0] DM_out = '0;
   logic        alu_overflow;
   logic [9:0]  pc;
   logic        IM_read, IM_write, IM_enable;
   logic        DM_read, DM_write, DM_enable;
   logic [11:0] DM_address;
   logic [31:0] DM_in;

   always #5 clk = ~clk;

   tinisoc_core dut (
      .clk          (clk),
      .rst          (rst),
      .instruction  (instruction),
      .alu_overflow (alu_overflow),
      .pc           (pc),
      .IM_read      (IM_read),
      .IM_write     (IM_write),
      .IM_enable    (IM_enable),
      .DM_read      (DM_read),
      .DM_write     (DM_write),
      .DM_enable    (DM_enable),
      .DM_address   (DM_address),
      .DM_in        (DM_in),
      .DM_out       (DM_out)
   );

   logic [31:0] im [0:255];
   logic [31:0] dm [0:1023];

   // Word-organised memories with one-cycle read latency.
   always @(posedge clk) begin
      if (IM_enable && IM_read) instruction <= im[pc[9:2]];
      if (DM_enable && DM_write) dm[DM_address[11:2]] <= DM_in;
      if (DM_enable && DM_read) DM_out <= dm[DM_address[11:2]];
   end

   typedef struct packed {
      logic [11:0] a;
      logic [31:0] d;
   } st_t;

   logic [9:0] exp_pc [$];
   logic       exp_ov [$];
   st_t        exp_st [$];

   int total = 0;
   int bad   = 0;
   bit mon_en = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic logic [31:0] enc_alu(input logic [4:0] sub,
      input logic [4:0] rt, input logic [4:0] ra, input logic [4:0] rb);
      return {1'b0, T_ALU1, rt, ra, rb, 5'b0, sub};
   endfunction

   function automatic logic [31:0] enc_i15(input logic [5:0] op,
      input logic [4:0] rt, input logic [4:0] ra, input logic [14:0] imm);
      return {1'b0, op, rt, ra, imm};
   endfunction

   function automatic logic [31:0] enc_movi(input logic [4:0] rt,
      input logic [19:0] imm);
      return {1'b0, T_MOVI, rt, imm};
   endfunction

   function automatic logic [31:0] enc_x(input logic [7:0] sub,
      input logic [4:0] rt, input logic [4:0] ra, input logic [4:0] rb,
      input logic [1:0] sv);
      return {1'b0, T_MEMX, rt, ra, rb, sv, sub};
   endfunction

   // Reference model state.
   logic [31:0] m_reg [32];
   logic [31:0] m_dm  [1024];
   logic        m_ov;

   function automatic bit ovf(input longint s);
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   // Execute one instruction at ISA level.
   task automatic model_step(input logic [31:0] ins);
      logic [5:0]  op;
      logic [4:0]  rt, ra, rb;
      logic [31:0] a, b, r, ea, s15;
      longint      sa, sb, si;
      int          sh;
      bit          wr, ld, stv;
      op  = ins[30:25];
      rt  = ins[24:20];
      ra  = ins[19:15];
      rb  = ins[14:10];
      a   = m_reg[ra];
      b   = m_reg[rb];
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      s15 = {{17{ins[14]}}, ins[14:0]};
      si  = longint'($signed(s15));
      sh  = int'(ins[14:10]);
      wr  = 1;
      ld  = 0;
      stv = 0;
      r   = '0;
      ea  = a + s15 * 4;
      case (op)
         T_ALU1: case (ins[4:0])
            5'd0: begin r = a + b; m_ov = ovf(sa + sb); end
            5'd1: begin r = a - b; m_ov = ovf(sa - sb); end
            5'd2: r = a & b;
            5'd3: r = a ^ b;
            5'd4: r = a | b;
            5'd8: r = a << sh;
            5'd9: r = a >> sh;
            5'd11: r = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
            default: wr = 0;
         endcase
         T_ADDI: begin r = a + s15; m_ov = ovf(sa + si); end
         T_ORI:  r = a | {17'b0, ins[14:0]};
         T_XORI: r = a ^ {17'b0, ins[14:0]};
         T_MOVI: r = {{12{ins[19]}}, ins[19:0]};
         T_LWI:  ld = 1;
         T_SWI:  stv = 1;
         T_MEMX: begin
            ea = a + b * (32'd1 << ins[9:8]);
            if (ins[7:0] == 8'd2) ld = 1;
            else if (ins[7:0] == 8'd10) stv = 1;
            else wr = 0;
         end
         default: wr = 0;
      endcase
      if (ld) r = m_dm[ea[11:2]];
      if (stv) begin
         wr = 0;
         exp_st.push_back('{a: ea[11:0], d: m_reg[rt]});
         m_dm[ea[11:2]] = m_reg[rt];
      end
      if (wr) m_reg[rt] = r;
   endtask

   function automatic logic [31:0] rand_ins();
      logic [31:0] ins;
      logic [4:0]  rt, ra, rb;
      logic [4:0]  subs [8];
      subs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd11};
      rt = 5'($urandom);
      ra = 5'($urandom);
      rb = 5'($urandom);
      case ($urandom_range(0, 9))
         0, 1, 8: ins = enc_alu(subs[$urandom_range(0, 7)], rt, ra, rb);
         2: case ($urandom_range(0, 2))
               0: ins = enc_i15(T_ADDI, rt, ra, 15'($urandom));
               1: ins = enc_i15(T_ORI, rt, ra, 15'($urandom));
               default: ins = enc_i15(T_XORI, rt, ra, 15'($urandom));
            endcase
         3: ins = enc_movi(rt, 20'($urandom));
         4: ins = enc_i15(T_LWI, rt, ra, 15'($urandom));
         5: ins = enc_i15(T_SWI, rt, ra, 15'($urandom));
         6: ins = enc_x(($urandom_range(0, 1) != 0) ? 8'd2 : 8'd10,
                        rt, ra, rb, 2'($urandom));
         7: case ($urandom_range(0, 3))
               0: ins = {1'b0, 6'b111111, 25'($urandom)};
               1: ins = {1'b0, 6'b000000, 25'($urandom)};
               2: ins = enc_alu(5'b00111, rt, ra, rb);
               default: ins = enc_x(8'h55, rt, ra, rb, 2'($urandom));
            endcase
         default: ins = enc_alu(5'd0, rt, ra, rb);
      endcase
      ins[31] = 1'($urandom);
      return ins;
   endfunction

   // Monitor: pops expectations whenever the DUT fetches or strobes DM.
   int ph = 0;
   bit seen = 0;
   int nfetch = 0;
   always @(negedge clk) begin
      if (mon_en) begin
         ph++;
         if (IM_read) begin
            if (seen) chk("fetch_gap", ph, 5);
            seen = 1;
            ph = 0;
            chk("im_strobes", {30'b0, IM_enable, IM_write}, 32'd2);
            if (exp_pc.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_fetch actual=%h required=none", pc);
            end else begin
               chk("pc", pc, exp_pc.pop_front());
            end
            if (nfetch > 0 && exp_ov.size() != 0)
               chk("alu_overflow", alu_overflow, exp_ov.pop_front());
            nfetch++;
         end
         if (DM_read) chk("dm_read_phase", ph, 3);
         if (DM_write) begin
            chk("dm_write_phase", ph, 3);
            chk("dm_enable", DM_enable, 1);
            if (exp_st.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_store actual=%h required=none",
                        DM_address);
            end else begin
               st_t e;
               e = exp_st.pop_front();
               chk("store_addr", DM_address, e.a);
               chk("store_data", DM_in, e.d);
            end
         end
      end
   end

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_strobes"},
          {26'b0, IM_read, IM_write, IM_enable,
           DM_read, DM_write, DM_enable}, 32'd0);
      chk({nm, "_pc"}, pc, 0);
      chk({nm, "_dm_addr"}, DM_address, 0);
      chk({nm, "_dm_in"}, DM_in, 0);
      chk({nm, "_ovf"}, alu_overflow, 0);
   endtask

   initial begin
      logic [9:0] mpc;
      bit found;
      for (int i = 0; i < 1024; i++) begin
         dm[i]   = $urandom;
         m_dm[i] = dm[i];
      end
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      m_ov = 0;

      im[0]  = enc_i15(T_ADDI, 5'd1, 5'd0, 15'd9);
      im[1]  = enc_i15(T_XORI, 5'd1, 5'd1, 15'd10);
      im[2]  = enc_movi(5'd0, 20'd3);
      im[3]  = enc_movi(5'd4, 20'd4);
      im[4]  = enc_i15(T_SWI, 5'd4, 5'd5, 15'd19);
      im[5]  = enc_movi(5'd8, 20'd8);
      im[6]  = enc_movi(5'd9, 20'd140);
      im[7]  = enc_x(8'd10, 5'd8, 5'd9, 5'd5, 2'd0);
      im[8]  = enc_i15(T_LWI, 5'd3, 5'd5, 15'd35);
      im[9]  = enc_movi(5'd2, 20'd4);
      im[10] = enc_alu(5'd9, 5'd2, 5'd2, 5'd2);
      im[11] = enc_alu(5'd8, 5'd2, 5'd2, 5'd3);
      im[12] = enc_movi(5'd6, 20'd12);
      im[13] = enc_alu(5'd11, 5'd7, 5'd6, 5'd0);
      im[14] = enc_movi(5'd10, 20'hFFFFF);
      im[15] = enc_alu(5'd9, 5'd10, 5'd10, 5'd1);
      im[16] = enc_movi(5'd11, 20'd1);
      im[17] = enc_alu(5'd0, 5'd12, 5'd10, 5'd11);
      im[18] = enc_alu(5'd2, 5'd13, 5'd10, 5'd11);
      im[19] = enc_movi(5'd14, 20'd5);
      im[20] = enc_movi(5'd15, 20'd2);
      im[21] = enc_alu(5'd1, 5'd16, 5'd14, 5'd15);
      for (int i = 0; i < 32; i++) begin
         im[N_DIR + i] = enc_i15(T_SWI, 5'(i), 5'd5, 15'(200 + i));
         im[224 + i]   = enc_i15(T_SWI, 5'(i), 5'd0, 15'(300 + i));
      end
      for (int i = N_DIR + 32; i < 224; i++) im[i] = rand_ins();

      mpc = '0;
      for (int k = 0; k < STEPS; k++) begin
         exp_pc.push_back(mpc);
         model_step(im[mpc[9:2]]);
         exp_ov.push_back(m_ov);
         mpc = mpc + 10'd4;
      end

      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_reset_outs("reset");
      @(posedge clk);
      #1 rst = 1'b1;
      mon_en = 1;

      for (int c = 0; c < STEPS * 5 + 50 && exp_pc.size() != 0; c++)
         @(posedge clk);
      chk("fetches_left", exp_pc.size(), 0);
      repeat (4) @(posedge clk);
      mon_en = 0;
      chk("stores_left", exp_st.size(), 0);

      rst = 1'b0;
      @(posedge clk);
      #1;
      dm[0] = 32'hDEADBEEF;
      im[0] = enc_movi(5'd1, 20'd5);
      im[1] = enc_i15(T_SWI, 5'd1, 5'd0, 15'd0);
      @(negedge clk);
      chk_reset_outs("reset2");
      @(posedge clk);
      #1 rst = 1'b1;
      found = 0;
      for (int c = 0; c < 30 && !found; c++) begin
         @(negedge clk);
         if (DM_write) found = 1;
      end
      chk("abort_store_seen", found, 1);
      chk("abort_store_data", DM_in, 32'd5);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_store_dm0", dm[0], 32'hDEADBEEF);
      @(negedge clk);
      chk_reset_outs("reset3");
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("restart_fetch", {31'b0, IM_read}, 32'd1);
      chk("restart_pc", pc, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
